// File: rtl/k005297_supbdlcntr_multi.sv
// Supplementary bubble data length counter: tracks a programmable-length burst
// in 1-bit or 4-bit mode, produces the shared count strobe and end/done pulses.
module k005297_supbdlcntr_multi #(
  parameter int CNTR_W = 4,
  parameter int STEP4  = 4
) (
  input  logic              i_MCLK,
  input  logic              i_RST,
  input  logic              i_CLK2M_PCEN_n,
  input  logic              i_SYS_RUN_FLAG,
  input  logic              i_START_n,
  input  logic [CNTR_W-1:0] i_LEN,
  input  logic              i_4BEN_n,
  input  logic              i_SLOT_STB,
  input  logic              i_WIN,
  input  logic              i_BDI_EN,
  input  logic              i_MSKREG_SR_LSB,
  input  logic              i_GLCNT_RD,
  output logic              o_SUPBDLCNTR_CNT,
  output logic              o_SUPBD_ACT_n,
  output logic              o_SUPBD_END_n,
  output logic [CNTR_W-1:0] o_REMAIN,
  output logic              o_DONE,
  output logic              o_OVERRUN
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, TERM} state_t;

  localparam logic [CNTR_W-1:0] ALL_ONES = '1;

  state_t            state_q, state_d;
  logic [CNTR_W-1:0] cnt_q, cnt_d;
  logic              act_n_q, act_n_d;
  logic              end_n_q, end_n_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              tick;
  logic              cnt_stb;
  logic [CNTR_W:0]   step;

  assign tick    = ~i_CLK2M_PCEN_n;
  assign cnt_stb = i_BDI_EN ? i_GLCNT_RD
                            : ((state_q == RUN) & i_WIN & i_MSKREG_SR_LSB);
  // One extra bit so a step equal to the counter range still compares correctly.
  assign step    = i_4BEN_n ? (CNTR_W+1)'(1) : (CNTR_W+1)'(STEP4);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_n_d = act_n_q;
    end_n_d = end_n_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    if (tick) begin
      end_n_d = 1'b1;
      done_d  = 1'b0;
      if (state_q != IDLE && !i_SYS_RUN_FLAG) begin
        // Abort wins over every other transition; overrun history is kept.
        end_n_d = 1'b0;
        act_n_d = 1'b1;
        cnt_d   = ALL_ONES;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!i_START_n && i_SYS_RUN_FLAG) begin
              cnt_d   = i_LEN;
              ovr_d   = 1'b0;
              act_n_d = 1'b0;
              state_d = ARM;
            end
          end
          ARM: begin
            if (i_SLOT_STB) state_d = (cnt_q == '0) ? TERM : RUN;
          end
          RUN: begin
            if (cnt_stb) begin
              if ({1'b0, cnt_q} > step) begin
                cnt_d = cnt_q - step[CNTR_W-1:0];
              end else begin
                cnt_d   = '0;
                state_d = TERM;
              end
            end
          end
          TERM: begin
            if (cnt_stb) ovr_d = 1'b1;
            if (i_SLOT_STB) begin
              end_n_d = 1'b0;
              done_d  = 1'b1;
              act_n_d = 1'b1;
              cnt_d   = ALL_ONES;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      cnt_q   <= ALL_ONES;
      act_n_q <= 1'b1;
      end_n_q <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_n_q <= act_n_d;
      end_n_q <= end_n_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_SUPBDLCNTR_CNT = cnt_stb;
  assign o_SUPBD_ACT_n    = act_n_q;
  assign o_SUPBD_END_n    = end_n_q;
  assign o_REMAIN         = cnt_q;
  assign o_DONE           = done_q;
  assign o_OVERRUN        = ovr_q;

endmodule

// File: tb/tb_k005297_supbdlcntr_multi.sv
// Scoreboard bench: a driver pushes the expected outputs from a behavioural
// burst model, a monitor pops and compares them on every falling edge.
module tb_k005297_supbdlcntr_multi;

  localparam int CNTR_W = 4;
  localparam int STEP4  = 4;
  localparam int MAXV   = (1 << CNTR_W) - 1;

  logic              clk = 1'b0;
  logic              rst, pcen_n, sysrun, start_n, b4en_n, slot, win, bdi, msk, gl;
  logic [CNTR_W-1:0] len;
  logic              cnt_o, act_n_o, end_n_o, done_o, ovr_o;
  logic [CNTR_W-1:0] rem_o;

  always #5 clk = ~clk;

  k005297_supbdlcntr_multi #(.CNTR_W(CNTR_W), .STEP4(STEP4)) dut (
    .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_SYS_RUN_FLAG(sysrun),
    .i_START_n(start_n), .i_LEN(len), .i_4BEN_n(b4en_n), .i_SLOT_STB(slot),
    .i_WIN(win), .i_BDI_EN(bdi), .i_MSKREG_SR_LSB(msk), .i_GLCNT_RD(gl),
    .o_SUPBDLCNTR_CNT(cnt_o), .o_SUPBD_ACT_n(act_n_o), .o_SUPBD_END_n(end_n_o),
    .o_REMAIN(rem_o), .o_DONE(done_o), .o_OVERRUN(ovr_o)
  );

  typedef struct {
    int rem;
    bit act_n, end_n, done, ovr, stb;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_cyc = 0;

  // Behavioural model: burst is either not running, waiting for its first
  // slot, counting down, or finished and waiting for the closing slot.
  localparam int P_IDLE = 0, P_WAIT = 1, P_COUNT = 2, P_FIN = 3;
  int m_phase, m_rem;
  bit m_busy, m_endp, m_done, m_ovr;

  function automatic bit model_strobe();
    if (bdi) return gl;
    return (m_phase == P_COUNT) && win && msk;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_rem = MAXV; m_busy = 0; m_endp = 0; m_done = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    bit s;
    int st;
    if (rst) begin
      model_reset();
      return;
    end
    if (pcen_n) return;
    s = model_strobe();
    st = b4en_n ? 1 : STEP4;
    m_endp = 0;
    m_done = 0;
    if (m_phase != P_IDLE && !sysrun) begin
      m_endp = 1; m_busy = 0; m_rem = MAXV; m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE:
        if (!start_n && sysrun) begin
          m_rem = len; m_ovr = 0; m_busy = 1; m_phase = P_WAIT;
        end
      P_WAIT:
        if (slot) m_phase = (m_rem == 0) ? P_FIN : P_COUNT;
      P_COUNT:
        if (s) begin
          m_rem = (m_rem - st > 0) ? m_rem - st : 0;
          if (m_rem == 0) m_phase = P_FIN;
        end
      default: begin
        if (s) m_ovr = 1;
        if (slot) begin
          m_endp = 1; m_done = 1; m_busy = 0; m_rem = MAXV; m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  // Called just after an edge with freshly driven inputs.
  task automatic cyc();
    exp_t e;
    e.rem = m_rem; e.act_n = !m_busy; e.end_n = !m_endp;
    e.done = m_done; e.ovr = m_ovr; e.stb = model_strobe();
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    n_cyc++;
    #1;
  endtask

  task automatic chk(string name, int act, int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, n_cyc, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("remain", int'(rem_o), e.rem);
        chk("act_n", int'(act_n_o), int'(e.act_n));
        chk("end_n", int'(end_n_o), int'(e.end_n));
        chk("done", int'(done_o), int'(e.done));
        chk("overrun", int'(ovr_o), int'(e.ovr));
        chk("cnt_strobe", int'(cnt_o), int'(e.stb));
      end
    end
  end

  task automatic idle_inputs();
    rst = 0; pcen_n = 0; sysrun = 1; start_n = 1; b4en_n = 1; slot = 0;
    win = 0; bdi = 0; msk = 0; gl = 0; len = '0;
  endtask

  task automatic start_burst(int l, bit mode_n);
    start_n = 0; len = CNTR_W'(l); b4en_n = mode_n; cyc();
    start_n = 1; slot = 1; cyc();
    slot = 0;
  endtask

  task automatic wcounts(int n);
    win = 1; msk = 1;
    repeat (n) cyc();
    win = 0; msk = 0;
  endtask

  task automatic close_slot();
    slot = 1; cyc();
    slot = 0; cyc(); cyc();
  endtask

  initial begin : driver
    idle_inputs();
    rst = 1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    cyc();  // reset state check
    rst = 0;
    cyc();

    // Normal 1-bit burst of 14
    start_burst(14, 1'b1); wcounts(14); close_slot();
    // 4-bit burst: 10 -> 6 -> 2 -> 0
    start_burst(10, 1'b0); wcounts(3); close_slot();
    // Overrun: two counts finish, a third read-side count overruns
    start_burst(2, 1'b1); wcounts(2);
    bdi = 1; gl = 1; cyc(); bdi = 0; gl = 0;
    close_slot();
    start_n = 0; len = 4'd3; cyc(); start_n = 1; cyc();  // restart clears overrun
    sysrun = 0; cyc(); sysrun = 1; cyc();
    // Abort with 5 remaining
    start_burst(9, 1'b1); wcounts(4);
    sysrun = 0; cyc(); sysrun = 1; cyc(); cyc();
    // Enable held off with counts asserted, then direction, then reset mid-burst
    start_burst(8, 1'b1);
    pcen_n = 1; win = 1; msk = 1; slot = 1;
    repeat (20) cyc();
    pcen_n = 0; slot = 0; win = 0; msk = 0;
    bdi = 1;
    for (int i = 0; i < 6; i++) begin gl = i[0]; cyc(); end
    bdi = 0; gl = 0;
    wcounts(2);
    rst = 1; pcen_n = 1; cyc(); rst = 0; pcen_n = 0; cyc();
    // Zero length
    start_burst(0, 1'b1); wcounts(2); close_slot();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      pcen_n  = ($urandom_range(0, 3) == 0);
      sysrun  = ($urandom_range(0, 29) != 0);
      start_n = ($urandom_range(0, 4) != 0);
      len     = CNTR_W'($urandom_range(0, MAXV));
      b4en_n  = ($urandom_range(0, 2) != 0);
      slot    = ($urandom_range(0, 5) == 0);
      win     = $urandom_range(0, 1);
      msk     = ($urandom_range(0, 3) != 0);
      bdi     = ($urandom_range(0, 4) == 0);
      gl      = $urandom_range(0, 1);
      cyc();
    end
    idle_inputs();
    cyc();
    @(negedge clk); #1;
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/k005297_supbdlcntr_multi.md
# k005297_supbdlcntr_multi

Parametrised supplementary bubble data length counter for the K005297 bubble memory controller datapath. It tracks the length of a supplementary-data burst in 1-bit or 4-bit transfer mode and generates the count strobe for the shared length counter. It then raises a slot-aligned end pulse back to the sequencer. The burst length is a programmable load instead of a fixed constant, so the counter can be reused for different page formats. The block adds an overrun flag, an abort path, a done pulse and a remaining-count readout.

## Interface
Parameters:
- CNTR_W, 4: counter width in bits; must be ≥ 3.
- STEP4, 4: decrement per count in 4-bit mode.

Ports:
- i_MCLK  in  1  master clock.
- i_RST  in  1  reset. Synchronous, active-high; overrides the clock enable.
- i_CLK2M_PCEN_n  in  1  active-low clock enable. All state updates happen only on ticks (MCLK edges with enable = 0).
- i_SYS_RUN_FLAG  in  1  system run. 0 aborts any active burst.
- i_START_n  in  1  active-low burst start request.
- i_LEN  in  CNTR_W  burst length in bit units, sampled at start.
- i_4BEN_n  in  1  0 = 4-bit mode (step STEP4), 1 = 1-bit mode (step 1).
- i_SLOT_STB  in  1  slot-boundary strobe from the rotation decoder.
- i_WIN  in  1  write-count window from the rotation decoder.
- i_BDI_EN  in  1  1 = read direction, 0 = write direction.
- i_MSKREG_SR_LSB  in  1  mask register shift-out bit (write qualifier).
- i_GLCNT_RD  in  1  read-side count request.
- o_SUPBDLCNTR_CNT  out  1  count strobe (combinational).
- o_SUPBD_ACT_n  out  1  0 while a burst is active.
- o_SUPBD_END_n  out  1  one-tick active-low end pulse.
- o_REMAIN  out  CNTR_W  remaining count.
- o_DONE  out  1  one-tick pulse on normal completion.
- o_OVERRUN  out  1  sticky overrun flag.

## Operation
- States: IDLE, ARM, RUN, TERM.
- Reset values: state IDLE; counter = all ones; o_SUPBD_ACT_n = 1; o_SUPBD_END_n = 1; o_DONE = 0; o_OVERRUN = 0.
- o_SUPBDLCNTR_CNT:
  - i_BDI_EN = 1: equals i_GLCNT_RD.
  - i_BDI_EN = 0: equals RUN & i_WIN & i_MSKREG_SR_LSB.
  - The strobe is output in every state. The counter only changes in RUN and TERM.
- Step: 1 when i_4BEN_n = 1, STEP4 when i_4BEN_n = 0. The mode is read at every tick.
- IDLE:
  - On a tick with i_START_n = 0 and i_SYS_RUN_FLAG = 1: counter ← i_LEN, o_OVERRUN ← 0, o_SUPBD_ACT_n ← 0, go to ARM.
  - In any other case, stay in IDLE.
- ARM: on a tick with i_SLOT_STB = 1, go to RUN, or to TERM if the counter is 0. Otherwise hold.
- RUN: on a tick with count = 1:
  - If counter > step: counter ← counter − step.
  - Otherwise: counter ← 0 (saturate, no wrap) and go to TERM.
- TERM:
  - A count tick sets o_OVERRUN = 1; the counter holds at 0.
  - On a tick with i_SLOT_STB = 1: o_SUPBD_END_n ← 0, o_DONE ← 1, o_SUPBD_ACT_n ← 1, counter ← all ones, go to IDLE.
  - If a count and the slot strobe arrive on the same tick, both actions happen.
- Abort: on a tick with i_SYS_RUN_FLAG = 0 in ARM, RUN or TERM:
  - o_SUPBD_END_n ← 0, o_SUPBD_ACT_n ← 1, counter ← all ones, go to IDLE.
  - o_DONE stays 0 and o_OVERRUN is kept.
  - Abort has priority over all other transitions.
- i_START_n outside IDLE is ignored.
- o_SUPBD_END_n and o_DONE go back to their inactive values on the next tick.
- o_REMAIN shows the counter register at all times.
- Reset in the middle of a burst gives the reset values on the next MCLK edge, whatever the enable.

## Timing
- All outputs except o_SUPBDLCNTR_CNT are registered and change only on ticks (or on reset).
- Start accepted on tick n → o_SUPBD_ACT_n = 0 after tick n.
- Slot strobe on tick k in TERM → o_SUPBD_END_n = 0 and o_DONE = 1 for ticks k..k+1, i.e. one enable period.
- Minimum burst of length L in 1-bit mode: 1 (start) + 1 (ARM slot) + L (counts) + 1 (TERM slot) ticks.
- o_SUPBDLCNTR_CNT has zero latency from its inputs.

## Test plan
- Normal 1-bit burst:
  - Stimulus: reset; i_LEN = 14, i_4BEN_n = 1; start; slot strobe; 14 write counts; slot strobe.
  - Required: o_REMAIN steps 14→0; o_SUPBD_END_n and o_DONE pulse one tick; o_SUPBD_ACT_n back to 1; o_OVERRUN = 0.
- 4-bit mode:
  - Stimulus: i_LEN = 10, i_4BEN_n = 0.
  - Required: o_REMAIN goes 10→6→2→0 after 3 counts; then TERM.
- Overrun:
  - Stimulus: i_LEN = 2; 3 counts before the TERM slot strobe.
  - Required: o_OVERRUN = 1 and o_REMAIN = 0; o_OVERRUN still 1 after done; cleared by the next start.
- Abort:
  - Stimulus: i_SYS_RUN_FLAG low in RUN with o_REMAIN = 5.
  - Required: one-tick o_SUPBD_END_n pulse; o_DONE = 0; o_REMAIN = all ones; state IDLE.
- Clock enable, direction and reset:
  - Stimulus: hold i_CLK2M_PCEN_n = 1 for 20 cycles with counts asserted; then toggle i_BDI_EN; then assert i_RST mid-burst.
  - Required:
    - No state change while the enable is high.
    - The strobe follows i_GLCNT_RD when i_BDI_EN = 1.
    - Reset gives all reset values on the next edge.
- Zero length: i_LEN = 0 → ARM→TERM on the first slot strobe; end pulse on the second slot strobe; no decrement.
